atm_ledger_arbiter: RTL
=======================

Name: atm_ledger_arbiter

Overview:
Shares one account ledger (balance memory) between NUM_TERM ATM terminals. Arbitrates requests round-robin and runs each granted transaction (balance query, withdraw, transfer) as a fixed multi-cycle read-check-write sequence, so concurrent terminals never interleave ledger accesses. Sits between the terminal front ends and a single-port ledger RAM with 1-cycle read latency.

Parameters:
NUM_TERM, 4, number of requesting terminals
IDX_W, 4, account index width (16 accounts)
AMT_W, 10, balance/amount width; balances saturate-check against 2^AMT_W-1

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
req  in  NUM_TERM  per-terminal request; held high until that terminal's done
op  in  2*NUM_TERM  per-terminal opcode: 00 balance, 01 withdraw, 10 transfer, 11 reserved
src_idx  in  IDX_W*NUM_TERM  per-terminal source account
dst_idx  in  IDX_W*NUM_TERM  per-terminal destination account (transfer only)
amount  in  AMT_W*NUM_TERM  per-terminal amount
grant  out  NUM_TERM  one-hot, registered; terminal owning the ledger
done  out  NUM_TERM  one-hot 1-cycle pulse, registered
status_ok  out  1  valid with done: 1 = success, 0 = declined
result_bal  out  AMT_W  valid with done: source balance after the transaction
mem_addr  out  IDX_W  ledger address (combinational from state and latched fields)
mem_we  out  1  ledger write enable
mem_wdata  out  AMT_W  ledger write data
mem_rdata  in  AMT_W  ledger read data, valid one cycle after mem_addr

Behaviour:
- Reset: state IDLE, grant=0, done=0, status_ok=0, result_bal=0, mem_we=0, rr pointer=0.
- States: IDLE, RD_SRC, RD_DST, CHECK, WR_SRC, WR_DST, RESP.
- IDLE: if any req, pick first requester at/after rr pointer; latch its op/src/dst/amount; set grant; -> RD_SRC. Otherwise stay.
- RD_SRC: mem_addr=src -> RD_DST. RD_DST: mem_addr=dst, capture src_bal -> CHECK. CHECK: capture dst_bal, evaluate.
- Balance: ok -> RESP. Withdraw: ok iff amount <= src_bal -> WR_SRC; else declined -> RESP.
- Transfer: ok iff amount <= src_bal, src != dst, and dst_bal + amount <= 2^AMT_W-1 (sum computed AMT_W+1 wide) -> WR_SRC; else declined -> RESP.
- Reserved op 11: declined, no writes.
- WR_SRC: mem_we=1, write src_bal-amount; -> WR_DST if transfer, else RESP. WR_DST: write dst_bal+amount -> RESP.
- RESP: done[g]=1, status_ok, result_bal (new or unchanged src_bal); grant cleared; rr pointer = g+1 mod NUM_TERM; -> IDLE.
- Latency from IDLE-cycle grant: done in cycle +4 (balance/declined), +5 (withdraw ok), +6 (transfer ok). Minimum 1 IDLE cycle between transactions.
- Amount 0 is legal and succeeds (writes unchanged values).
- req dropped mid-transaction: ignored; transaction completes and done still pulses.
- req still high after done: re-eligible, lowest priority.
- mem_we=0 in every state except WR_SRC/WR_DST.
- Reset mid-operation: returns to IDLE next edge, no done pulse. Reset is not transactional: a write whose cycle coincides with reset commits (ledger is not reset).

Decomposition:
- Shared package atm_pkg: opcode constants, state encoding, default IDX_W/AMT_W.
- Sub-module rr_arbiter: combinational one-hot pick from req and rr pointer.
- Ledger RAM stays external.

Test Plan:
- Term1 withdraw src=3 amt=40, ledger[3]=100 -> grant=0010, done[1] at cycle +5, status_ok=1, result_bal=60, ledger[3]=60.
- Term0 withdraw src=3 amt=150, ledger[3]=100 -> done at +4, status_ok=0, result_bal=100, mem_we never asserted.
- ledger[5]=1000, ledger[2]=100: transfer 2->5 amt=30 -> declined (1030>1023). Then amt=23 -> ok, ledger[5]=1023, ledger[2]=77, result_bal=77.
- req=1111 held, balance ops -> grants in order 0,1,2,3,0; grant never multi-hot; no overlapping mem accesses.
- Term0 and term2 both withdraw 60 from account 4 (=100) in the same cycle -> term0 ok (result 40), term2 declined (result 40); ledger[4]=40.
- Transfer started, reset asserted during RD_DST -> next cycle grant=0, no done, ledger unchanged, next grant starts from terminal 0.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM ledger arbiter: default widths, opcodes and
// the transaction sequencer state encoding.
package atm_pkg;

  localparam int unsigned DEF_NUM_TERM = 4;
  localparam int unsigned DEF_IDX_W    = 4;
  localparam int unsigned DEF_AMT_W    = 10;
  localparam int unsigned OP_W         = 2;

  // Terminal opcodes
  typedef enum logic [OP_W-1:0] {
    OP_BAL      = 2'b00,
    OP_WITHDRAW = 2'b01,
    OP_XFER     = 2'b10,
    OP_RSVD     = 2'b11
  } op_e;

  // Sequencer states: one fixed read-check-write pass per granted transaction
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_SRC = 3'd1,
    ST_RD_DST = 3'd2,
    ST_CHECK  = 3'd3,
    ST_WR_SRC = 3'd4,
    ST_WR_DST = 3'd5,
    ST_RESP   = 3'd6
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
// Ports:
//   req          - request vector
//   ptr          - highest-priority index this round
//   pick_c       - one-hot winner (zero when no request)
//   pick_idx_c   - binary index of the winner
//   pick_valid_c - any request present
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick_c,
  output logic [PTR_W-1:0] pick_idx_c,
  output logic             pick_valid_c
);

  // Scan from ptr with wraparound; first hit wins
  always_comb begin
    logic [PTR_W-1:0] k;
    pick_c       = '0;
    pick_idx_c   = '0;
    pick_valid_c = 1'b0;
    k            = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = PTR_W'((32'(ptr) + i) % N);
      if (!pick_valid_c && req[k]) begin
        pick_valid_c = 1'b1;
        pick_c[k]    = 1'b1;
        pick_idx_c   = k;
      end
    end
  end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Shares one single-port ledger RAM (1-cycle read latency) between NUM_TERM
// ATM terminals. Requests are granted round-robin and each granted
// transaction runs a fixed read-src, read-dst, check, write sequence so
// ledger accesses of different terminals never interleave.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   req/op/src_idx/dst_idx/amount - per-terminal request and fields (packed)
//   grant                 - one-hot owner of the ledger (registered)
//   done                  - one-hot completion pulse (registered)
//   status_ok, result_bal - outcome and source balance, valid with done
//   mem_addr/mem_we/mem_wdata - ledger RAM request (combinational)
//   mem_rdata             - ledger RAM read data, one cycle after mem_addr
module atm_ledger_arbiter
  import atm_pkg::*;
#(
  parameter int unsigned NUM_TERM = DEF_NUM_TERM,
  parameter int unsigned IDX_W    = DEF_IDX_W,
  parameter int unsigned AMT_W    = DEF_AMT_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_TERM-1:0]       req,
  input  logic [OP_W*NUM_TERM-1:0]  op,
  input  logic [IDX_W*NUM_TERM-1:0] src_idx,
  input  logic [IDX_W*NUM_TERM-1:0] dst_idx,
  input  logic [AMT_W*NUM_TERM-1:0] amount,
  output logic [NUM_TERM-1:0]       grant,
  output logic [NUM_TERM-1:0]       done,
  output logic                      status_ok,
  output logic [AMT_W-1:0]          result_bal,
  output logic [IDX_W-1:0]          mem_addr,
  output logic                      mem_we,
  output logic [AMT_W-1:0]          mem_wdata,
  input  logic [AMT_W-1:0]          mem_rdata
);

  localparam int unsigned TERM_W = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;
  localparam logic [AMT_W:0] BAL_MAX = {1'b0, {AMT_W{1'b1}}};

  // Per-terminal views of the packed request fields
  logic [OP_W-1:0]  op_arr  [NUM_TERM];
  logic [IDX_W-1:0] src_arr [NUM_TERM];
  logic [IDX_W-1:0] dst_arr [NUM_TERM];
  logic [AMT_W-1:0] amt_arr [NUM_TERM];

  for (genvar t = 0; t < NUM_TERM; t++) begin : g_unpack
    assign op_arr[t]  = op[OP_W*t +: OP_W];
    assign src_arr[t] = src_idx[IDX_W*t +: IDX_W];
    assign dst_arr[t] = dst_idx[IDX_W*t +: IDX_W];
    assign amt_arr[t] = amount[AMT_W*t +: AMT_W];
  end

  state_e                state_q, state_d;
  logic [NUM_TERM-1:0]   grant_q, grant_d;
  logic [NUM_TERM-1:0]   done_q, done_d;
  logic                  status_ok_q, status_ok_d;
  logic [AMT_W-1:0]      result_bal_q, result_bal_d;
  logic [TERM_W-1:0]     rr_q, rr_d;
  logic [TERM_W-1:0]     g_q, g_d;
  op_e                   op_q, op_d;
  logic [IDX_W-1:0]      src_q, src_d;
  logic [IDX_W-1:0]      dst_q, dst_d;
  logic [AMT_W-1:0]      amt_q, amt_d;
  logic [AMT_W-1:0]      src_bal_q, src_bal_d;
  logic [AMT_W-1:0]      dst_bal_q, dst_bal_d;

  logic [NUM_TERM-1:0]   pick_c;
  logic [TERM_W-1:0]     pick_idx_c;
  logic                  pick_valid_c;

  logic [AMT_W:0]        dst_sum_c;
  logic                  chk_ok_c;
  logic                  chk_write_c;
  logic [TERM_W-1:0]     rr_next_c;

  rr_arbiter #(
    .N     (NUM_TERM),
    .PTR_W (TERM_W)
  ) u_rr_arbiter (
    .req          (req),
    .ptr          (rr_q),
    .pick_c       (pick_c),
    .pick_idx_c   (pick_idx_c),
    .pick_valid_c (pick_valid_c)
  );

  // Decision in CHECK: mem_rdata carries the destination balance this cycle
  always_comb begin
    dst_sum_c   = {1'b0, mem_rdata} + {1'b0, amt_q};
    chk_ok_c    = 1'b0;
    chk_write_c = 1'b0;
    case (op_q)
      OP_BAL: chk_ok_c = 1'b1;
      OP_WITHDRAW: begin
        chk_ok_c    = (amt_q <= src_bal_q);
        chk_write_c = chk_ok_c;
      end
      OP_XFER: begin
        chk_ok_c    = (amt_q <= src_bal_q) && (src_q != dst_q) &&
                      (dst_sum_c <= BAL_MAX);
        chk_write_c = chk_ok_c;
      end
      default: ;
    endcase
  end

  assign rr_next_c = (g_q == TERM_W'(NUM_TERM - 1)) ? '0 : g_q + TERM_W'(1);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      status_ok_q  <= 1'b0;
      result_bal_q <= '0;
      rr_q         <= '0;
      g_q          <= '0;
      op_q         <= OP_BAL;
      src_q        <= '0;
      dst_q        <= '0;
      amt_q        <= '0;
      src_bal_q    <= '0;
      dst_bal_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      status_ok_q  <= status_ok_d;
      result_bal_q <= result_bal_d;
      rr_q         <= rr_d;
      g_q          <= g_d;
      op_q         <= op_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      amt_q        <= amt_d;
      src_bal_q    <= src_bal_d;
      dst_bal_q    <= dst_bal_d;
    end
  end

  // Next state and registered outputs
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    done_d       = '0;
    status_ok_d  = status_ok_q;
    result_bal_d = result_bal_q;
    rr_d         = rr_q;
    g_d          = g_q;
    op_d         = op_q;
    src_d        = src_q;
    dst_d        = dst_q;
    amt_d        = amt_q;
    src_bal_d    = src_bal_q;
    dst_bal_d    = dst_bal_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          grant_d = pick_c;
          g_d     = pick_idx_c;
          op_d    = op_e'(op_arr[pick_idx_c]);
          src_d   = src_arr[pick_idx_c];
          dst_d   = dst_arr[pick_idx_c];
          amt_d   = amt_arr[pick_idx_c];
          state_d = ST_RD_SRC;
        end
      end
      ST_RD_SRC: state_d = ST_RD_DST;
      ST_RD_DST: begin
        src_bal_d = mem_rdata;
        state_d   = ST_CHECK;
      end
      ST_CHECK: begin
        dst_bal_d = mem_rdata;
        if (chk_write_c) begin
          state_d = ST_WR_SRC;
        end else begin
          done_d       = grant_q;
          status_ok_d  = chk_ok_c;
          result_bal_d = src_bal_q;
          state_d      = ST_RESP;
        end
      end
      ST_WR_SRC: begin
        if (op_q == OP_XFER) begin
          state_d = ST_WR_DST;
        end else begin
          done_d       = grant_q;
          status_ok_d  = 1'b1;
          result_bal_d = src_bal_q - amt_q;
          state_d      = ST_RESP;
        end
      end
      ST_WR_DST: begin
        done_d       = grant_q;
        status_ok_d  = 1'b1;
        result_bal_d = src_bal_q - amt_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        grant_d = '0;
        rr_d    = rr_next_c;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ledger port is a pure decode of the current state and latched fields
  always_comb begin
    mem_addr  = src_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      ST_RD_DST: mem_addr = dst_q;
      ST_WR_SRC: begin
        mem_we    = 1'b1;
        mem_wdata = src_bal_q - amt_q;
      end
      ST_WR_DST: begin
        mem_addr  = dst_q;
        mem_we    = 1'b1;
        mem_wdata = dst_bal_q + amt_q;
      end
      default: ;
    endcase
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign status_ok  = status_ok_q;
  assign result_bal = result_bal_q;

endmodule
